mem_bus_port: RTL and testbench

Memory-side bus port for the 16-bit datapath. Captures the shared datapath bus into MAR and MDR, runs a fixed-latency SRAM read or write cycle with a ready handshake toward the control FSM, and presents MDR back as the gateMDR source for the bus gate multiplexer. It sits between the gated bus and the external SRAM; the control FSM drives it with load and request strobes.

---
 rtl/mem_bus_port_if.sv | 42 ++++
 rtl/mem_bus_port.sv | 143 ++++++++++++++
 tb/tb_mem_bus_port.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_port_if.sv
// mem_bus_port_if
//   Groups the bus-side and SRAM-side signals of mem_bus_port.
//   master : the driver side (control FSM, gated bus, SRAM read data).
//   slave  : the memory bus port itself.
//   Signals:
//     bus[15:0]            gated datapath bus
//     ld_mar, ld_mdr       register load strobes
//     mem_req, mem_wr      transaction start and type (0 = read, 1 = write)
//     gate_sel[3:0]        bus gate selects {MARMUX, ALU, MDR, PC}
//     data_from_sram[15:0] SRAM read data
//     mar[15:0], mdr[15:0] address / data registers
//     data_to_sram[15:0]   SRAM write data (mirrors mdr)
//     ce_n, oe_n, we_n     active-low SRAM strobes
//     r, busy, gate_err    ready pulse, busy flag, sticky gate-select error
interface mem_bus_port_if;
    logic [15:0] bus;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  gate_sel;
    logic [15:0] data_from_sram;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] data_to_sram;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        r;
    logic        busy;
    logic        gate_err;

    modport master (
        output bus, ld_mar, ld_mdr, mem_req, mem_wr, gate_sel, data_from_sram,
        input  mar, mdr, data_to_sram, ce_n, oe_n, we_n, r, busy, gate_err
    );

    modport slave (
        input  bus, ld_mar, ld_mdr, mem_req, mem_wr, gate_sel, data_from_sram,
        output mar, mdr, data_to_sram, ce_n, oe_n, we_n, r, busy, gate_err
    );
endinterface

// File: rtl/mem_bus_port.sv
// mem_bus_port
//   Memory-side bus port for the 16-bit datapath. Captures the gated bus
//   into MAR/MDR, runs a fixed-latency SRAM read or write with a one-cycle
//   ready pulse, and presents MDR as the gateMDR source.
//
//   Parameters:
//     WAIT_CYCLES  SRAM access cycles per transaction, legal range 1..15.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     mb     mem_bus_port_if.slave (bus, strobes, SRAM data, status)
//
//   Optional feature:
//     GATE_ONEHOT_CHECK_EN  when defined, gate_sel is checked every cycle
//                           and any value with more than one bit set makes
//                           gate_err stick high until reset. When undefined,
//                           gate_err is tied low and gate_sel is ignored.
//
//   All outputs come straight from registers or from a decode of the
//   registered state, so there is no input-to-output combinational path.
module mem_bus_port #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_port_if.slave mb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        wr_reg, wr_next;
    logic [15:0] mar_reg, mar_next;
    logic [15:0] mdr_reg, mdr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            wr_reg    <= 1'b0;
            mar_reg   <= 16'h0000;
            mdr_reg   <= 16'h0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wr_reg    <= wr_next;
            mar_reg   <= mar_next;
            mdr_reg   <= mdr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_next    = wr_reg;
        mar_next   = mar_reg;
        mdr_next   = mdr_reg;

        case (state_reg)
            IDLE: begin
                // Loads and the request are evaluated together, so a load
                // issued with the request is what the transaction uses.
                if (mb.ld_mar) begin
                    mar_next = mb.bus;
                end
                if (mb.ld_mdr) begin
                    mdr_next = mb.bus;
                end
                if (mb.mem_req) begin
                    wr_next    = mb.mem_wr;
                    cnt_next   = 4'd0;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // MAR/MDR frozen; only the last access edge touches MDR.
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = 4'd0;
                    state_next = DONE;
                    if (!wr_reg) begin
                        mdr_next = mb.data_from_sram;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes decode from registered state and the latched transaction type.
    assign mb.mar          = mar_reg;
    assign mb.mdr          = mdr_reg;
    assign mb.data_to_sram = mdr_reg;
    assign mb.ce_n         = (state_reg != ACCESS);
    assign mb.oe_n         = !((state_reg == ACCESS) && !wr_reg);
    assign mb.we_n         = !((state_reg == ACCESS) && wr_reg);
    assign mb.r            = (state_reg == DONE);
    assign mb.busy         = (state_reg != IDLE);

`ifdef GATE_ONEHOT_CHECK_EN
    // seen[gi] is high when any select below bit gi is set; a bit that is
    // set while seen is already high means two or more selects are active.
    logic [4:0] seen;
    logic [3:0] clash;
    logic       gate_err_reg;

    assign seen[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign clash[gi]    = mb.gate_sel[gi] & seen[gi];
            assign seen[gi + 1] = seen[gi] | mb.gate_sel[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_err_reg <= 1'b0;
        end else if (|clash) begin
            gate_err_reg <= 1'b1;
        end
    end

    assign mb.gate_err = gate_err_reg;
`else
    assign mb.gate_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_port.sv
// tb_mem_bus_port
//   Randomized and directed bench for mem_bus_port. A behavioural model
//   (expected MAR/MDR, an independent reference memory and the transaction
//   timeline counted in cycles) supplies every expected value. A simple SRAM
//   model answers the DUT strobes.
module tb_mem_bus_port;

    localparam int W = 2;

    logic clk;
    logic reset;

    mem_bus_port_if mb ();

    mem_bus_port #(.WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .mb    (mb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model driven only by the DUT strobes.
    logic [15:0] sram    [65536];
    // Reference memory updated only by the bench's model.
    logic [15:0] ref_mem [65536];

    always @(posedge clk) begin
        if (!mb.ce_n && !mb.we_n) begin
            sram[mb.mar] <= mb.data_to_sram;
        end
    end

    always_comb begin
        if (!mb.ce_n && !mb.oe_n) begin
            mb.data_from_sram = sram[mb.mar];
        end else begin
            mb.data_from_sram = 16'hxxxx;
        end
    end

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] exp_mar;
    logic [15:0] exp_mdr;
    logic        exp_err;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        mb.bus     = 16'h0000;
        mb.ld_mar  = 1'b0;
        mb.ld_mdr  = 1'b0;
        mb.mem_req = 1'b0;
        mb.mem_wr  = 1'b0;
    endtask

    // Idle-cycle load; called at a negedge while IDLE.
    task automatic load(input bit lm, input bit ld, input logic [15:0] val);
        mb.bus    = val;
        mb.ld_mar = lm;
        mb.ld_mdr = ld;
        @(negedge clk);
        clear_inputs();
        if (lm) exp_mar = val;
        if (ld) exp_mdr = val;
        check("load_mar", mb.mar, exp_mar);
        check("load_mdr", mb.mdr, exp_mdr);
        $display("load  lm=%0d ld=%0d val=%h mar=%h mdr=%h", lm, ld, val, mb.mar, mb.mdr);
    endtask

    // One transaction, entered at a negedge in IDLE. Request edge is the
    // next posedge (k); ACCESS k+1..k+W, DONE k+W+1, IDLE k+W+2.
    // Loads, requests and bus noise are thrown at the DUT during ACCESS.
    task automatic txn(input bit wr, input bit lm, input bit ld, input logic [15:0] val);
        mb.bus     = val;
        mb.ld_mar  = lm;
        mb.ld_mdr  = ld;
        mb.mem_req = 1'b1;
        mb.mem_wr  = wr;
        if (lm) exp_mar = val;
        if (ld) exp_mdr = val;
        @(negedge clk);
        for (int j = 1; j <= W; j++) begin
            check("acc_ce_n", 16'(mb.ce_n), 16'(0));
            check("acc_oe_n", 16'(mb.oe_n), 16'(wr));
            check("acc_we_n", 16'(mb.we_n), 16'(!wr));
            check("acc_r",    16'(mb.r),    16'(0));
            check("acc_busy", 16'(mb.busy), 16'(1));
            check("acc_mar",  mb.mar,       exp_mar);
            check("acc_dout", mb.data_to_sram, exp_mdr);
            mb.bus     = 16'($urandom);
            mb.ld_mar  = 1'b1;
            mb.ld_mdr  = 1'b1;
            mb.mem_req = 1'b1;
            mb.mem_wr  = 1'($urandom);
            @(negedge clk);
        end
        clear_inputs();
        if (wr) ref_mem[exp_mar] = exp_mdr;
        else    exp_mdr = ref_mem[exp_mar];
        check("done_r",    16'(mb.r),    16'(1));
        check("done_busy", 16'(mb.busy), 16'(1));
        check("done_strb", {13'd0, mb.ce_n, mb.oe_n, mb.we_n}, 16'h0007);
        check("done_mdr",  mb.mdr, exp_mdr);
        check("done_mar",  mb.mar, exp_mar);
        @(negedge clk);
        check("idle_r",    16'(mb.r),    16'(0));
        check("idle_busy", 16'(mb.busy), 16'(0));
        check("idle_ce_n", 16'(mb.ce_n), 16'(1));
        check("idle_mdr",  mb.mdr, exp_mdr);
        if (wr) check("sram_wr", sram[exp_mar], ref_mem[exp_mar]);
        $display("txn   wr=%0d addr=%h data=%h mdr=%h", wr, exp_mar, exp_mdr, mb.mdr);
    endtask

    task automatic gate_step(input logic [3:0] sel);
        mb.gate_sel = sel;
        @(negedge clk);
`ifdef GATE_ONEHOT_CHECK_EN
        if ($countones(sel) > 1) exp_err = 1'b1;
`endif
        check("gate_err", 16'(mb.gate_err), 16'(exp_err));
        $display("gate  sel=%b gate_err=%0d", sel, mb.gate_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        bit          w;
        int unsigned mode;

        for (int i = 0; i < 65536; i++) begin
            d = 16'($urandom);
            sram[i]    = d;
            ref_mem[i] = d;
        end
        sram[16'h1234]    = 16'hBEEF;
        ref_mem[16'h1234] = 16'hBEEF;

        clear_inputs();
        mb.gate_sel = 4'b0000;
        exp_err     = 1'b0;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_mar = 16'h0000;
        exp_mdr = 16'h0000;

        // Reset state
        check("rst_mar",  mb.mar, 16'h0000);
        check("rst_mdr",  mb.mdr, 16'h0000);
        check("rst_strb", {13'd0, mb.ce_n, mb.oe_n, mb.we_n}, 16'h0007);
        check("rst_r",    16'(mb.r),    16'(0));
        check("rst_busy", 16'(mb.busy), 16'(0));
        check("rst_gerr", 16'(mb.gate_err), 16'(0));
        $display("reset mar=%h mdr=%h busy=%0d", mb.mar, mb.mdr, mb.busy);

        // Directed read from 0x1234
        load(1'b1, 1'b0, 16'h1234);
        txn(1'b0, 1'b0, 1'b0, 16'h0000);
        check("read_beef", mb.mdr, 16'hBEEF);

        // Directed write 0xA5A5 -> 0x00F0, MDR loaded with the request
        load(1'b1, 1'b0, 16'h00F0);
        txn(1'b1, 1'b0, 1'b1, 16'hA5A5);
        check("write_a5a5", sram[16'h00F0], 16'hA5A5);

        // Read back the written word, MAR loaded together with the request
        txn(1'b0, 1'b1, 1'b0, 16'h00F0);
        check("readback", mb.mdr, 16'hA5A5);

        // Randomized transactions, mostly back-to-back
        for (int i = 0; i < 24; i++) begin
            a    = 16'($urandom);
            d    = 16'($urandom);
            w    = 1'($urandom);
            mode = $urandom_range(0, 2);
            case (mode)
                0: begin
                    load(1'b1, 1'b0, a);
                    txn(w, 1'b0, w, d);
                end
                1: begin
                    txn(w, 1'b1, 1'b0, a);
                end
                default: begin
                    load(1'b0, 1'b1, d);
                    load(1'b1, 1'b0, a);
                    txn(w, 1'b0, 1'b0, 16'h0000);
                end
            endcase
        end

        // Reset in the 2nd ACCESS cycle of a read
        load(1'b0, 1'b1, 16'h5A5A);
        mb.mem_req = 1'b1;
        mb.mem_wr  = 1'b0;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("mid_busy", 16'(mb.busy), 16'(1));
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_mar = 16'h0000;
        exp_mdr = 16'h0000;
        check("mid_mdr",  mb.mdr, 16'h0000);
        check("mid_mar",  mb.mar, 16'h0000);
        check("mid_busy0", 16'(mb.busy), 16'(0));
        check("mid_strb", {13'd0, mb.ce_n, mb.oe_n, mb.we_n}, 16'h0007);
        for (int i = 0; i < 4; i++) begin
            check("mid_no_r", 16'(mb.r), 16'(0));
            @(negedge clk);
        end
        check("mid_mdr_hold", mb.mdr, 16'h0000);
        $display("mreset mdr=%h r=%0d busy=%0d", mb.mdr, mb.r, mb.busy);

        // Gate select checker
        gate_step(4'b0000);
        gate_step(4'b0100);
        gate_step(4'b0110);
        gate_step(4'b0001);
        gate_step(4'b0001);
        gate_step(4'b0000);
        mb.gate_sel = 4'b0000;
        reset       = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_err = 1'b0;
        check("gate_rst", 16'(mb.gate_err), 16'(0));
        for (int i = 0; i < 6; i++) begin
            gate_step(4'(1 << $urandom_range(0, 3)));
        end
        gate_step(4'b1001);
        gate_step(4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
